// File: rtl/sprite_if.sv
// Bundles the VGA-timing inputs, sprite position and address/progress outputs
// of the sprite address generator.
interface sprite_if;
  logic        frame_start;
  logic        line_start;
  logic        de;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic [15:0] rom_addr16;
  logic [15:0] pix_cnt;
  logic        pix_vld;
  logic        frame_done;

  modport master (
    output frame_start, line_start, de, h_cnt, v_cnt, pos_x, pos_y,
    input  rom_addr16, pix_cnt, pix_vld, frame_done
  );

  modport slave (
    input  frame_start, line_start, de, h_cnt, v_cnt, pos_x, pos_y,
    output rom_addr16, pix_cnt, pix_vld, frame_done
  );
endinterface

// File: rtl/sprite_addr_gen.sv
// Sprite ROM address and box-pixel counter for a BOX_W x BOX_H sprite placed at
// a per-frame latched screen position.
//
//   state  | meaning
//   IDLE   | out of reset, waiting for the first frame_start; nothing counted
//   ACTIVE | frame in progress, box pixels addressed and counted
//   DONE   | last box pixel addressed; ignore pixels until next frame_start
module sprite_addr_gen #(
  parameter int BOX_W = 200,
  parameter int BOX_H = 200
) (
  input  logic     clk,
  input  logic     rst_n,
  sprite_if.slave  sif
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [10:0] W11      = 11'(BOX_W);
  localparam logic [10:0] H11      = 11'(BOX_H);
  localparam logic [10:0] W11_LAST = 11'(BOX_W - 1);
  localparam logic [10:0] H11_LAST = 11'(BOX_H - 1);
  localparam logic [15:0] W16      = 16'(BOX_W);

  state_t      state_q, state_d;
  logic [10:0] px_q, px_d;
  logic [10:0] py_q, py_d;
  logic [15:0] row_base_q, row_base_d;
  logic        row_hit_q, row_hit_d;
  logic [15:0] rom_addr_q, rom_addr_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic        addr_upd_q, addr_upd_d;
  logic        pix_vld_q, pix_vld_d;
  logic        frame_done_q, frame_done_d;

  logic [10:0] dx, dy;
  logic        in_box, hit, last_px;
  logic [15:0] base_eff;

  // Unsigned wrap makes pixels left of / above the box compare as huge.
  always_comb begin
    dx       = sif.h_cnt - px_q;
    dy       = sif.v_cnt - py_q;
    in_box   = sif.de & (dx < W11) & (dy < H11);
    base_eff = (sif.line_start && row_hit_q) ? row_base_q + W16 : row_base_q;
    hit      = in_box & (state_q == ACTIVE) & ~sif.frame_start;
    last_px  = hit & (dx == W11_LAST) & (dy == H11_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sif.frame_start) state_d = ACTIVE;
    else if (last_px)    state_d = DONE;
  end

  always_comb begin
    px_d         = px_q;
    py_d         = py_q;
    row_base_d   = row_base_q;
    row_hit_d    = row_hit_q;
    rom_addr_d   = rom_addr_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    addr_upd_d   = hit;
    pix_vld_d    = addr_upd_q;
    if (sif.frame_start) begin
      px_d       = sif.pos_x;
      py_d       = sif.pos_y;
      row_base_d = '0;
      row_hit_d  = 1'b0;
      pix_cnt_d  = '0;
    end else begin
      row_base_d = base_eff;
      row_hit_d  = (row_hit_q & ~sif.line_start) | in_box;
      if (hit) begin
        rom_addr_d   = base_eff + {5'b0, dx};
        pix_cnt_d    = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
        frame_done_d = last_px;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q         <= '0;
      py_q         <= '0;
      row_base_q   <= '0;
      row_hit_q    <= 1'b0;
      rom_addr_q   <= '0;
      pix_cnt_q    <= '0;
      addr_upd_q   <= 1'b0;
      pix_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      px_q         <= px_d;
      py_q         <= py_d;
      row_base_q   <= row_base_d;
      row_hit_q    <= row_hit_d;
      rom_addr_q   <= rom_addr_d;
      pix_cnt_q    <= pix_cnt_d;
      addr_upd_q   <= addr_upd_d;
      pix_vld_q    <= pix_vld_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sif.rom_addr16 = rom_addr_q;
  assign sif.pix_cnt    = pix_cnt_q;
  assign sif.pix_vld    = pix_vld_q;
  assign sif.frame_done = frame_done_q;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Bench for sprite_addr_gen: small raster with a 20x10 sprite, a frame-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_sprite_addr_gen;
  localparam int BW    = 20;
  localparam int BH    = 10;
  localparam int SCR_W = 64;
  localparam int SCR_H = 32;
  localparam int H_BL  = 4;
  localparam int V_BL  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_if sif ();

  sprite_addr_gen #(.BOX_W(BW), .BOX_H(BH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  int vectors     = 0;
  int miscompares = 0;
  int done_pulses = 0;
  bit cmp_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a box pixel's row index is the number of distinct screen
  // rows that already held box pixels since the frame started.
  int m_rows [int];
  bit m_armed, m_done, m_pend, m_vld, m_fd;
  int m_px, m_py, m_cnt, m_addr;

  always @(posedge clk or negedge rst_n) begin
    int dx, dy;
    if (!rst_n) begin
      m_armed = 0; m_done = 0; m_pend = 0; m_vld = 0; m_fd = 0;
      m_px = 0; m_py = 0; m_cnt = 0; m_addr = 0;
      m_rows.delete();
    end else begin
      m_fd   = 0;
      m_vld  = m_pend;
      m_pend = 0;
      if (sif.frame_start) begin
        m_armed = 1; m_done = 0; m_cnt = 0;
        m_px = int'(sif.pos_x); m_py = int'(sif.pos_y);
        m_rows.delete();
      end else if (m_armed && !m_done && sif.de) begin
        dx = (int'(sif.h_cnt) - m_px) & 2047;
        dy = (int'(sif.v_cnt) - m_py) & 2047;
        if (dx < BW && dy < BH) begin
          if (!m_rows.exists(int'(sif.v_cnt))) m_rows[int'(sif.v_cnt)] = m_rows.num();
          m_addr = (m_rows[int'(sif.v_cnt)] * BW + dx) & 16'hFFFF;
          m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
          m_pend = 1;
          if (dx == BW - 1 && dy == BH - 1) begin
            m_done = 1;
            m_fd   = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("rom_addr16", sif.rom_addr16, m_addr);
      check("pix_cnt",    sif.pix_cnt,    m_cnt);
      check("pix_vld",    sif.pix_vld,    m_vld);
      check("frame_done", sif.frame_done, m_fd);
      if (sif.frame_done) done_pulses++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rom_addr16"}, sif.rom_addr16, 0);
    check({tag, " pix_cnt"},    sif.pix_cnt,    0);
    check({tag, " pix_vld"},    sif.pix_vld,    0);
    check({tag, " frame_done"}, sif.frame_done, 0);
  endtask

  // Literal expectations for the pixel presented in the previous cycle.
  task automatic probe(input int test, input int h, input int v, input bit de, input bit fs);
    if (!de) return;
    case (test)
      1: begin
        if (h == 10 && v == 5)  check("basic first addr", sif.rom_addr16, 0);
        if (h == 29 && v == 5)  check("basic row end",    sif.rom_addr16, 19);
        if (h == 10 && v == 6)  check("basic row2 start", sif.rom_addr16, 20);
        if (h == 29 && v == 14) begin
          check("basic last addr",  sif.rom_addr16, 199);
          check("basic frame_done", sif.frame_done, 1);
        end
      end
      2: begin
        if (h == 54 && v == 0) check("clip first",   sif.rom_addr16, 0);
        if (h == 63 && v == 0) check("clip row end", sif.rom_addr16, 9);
        if (h == 54 && v == 1) check("clip row2",    sif.rom_addr16, 20);
      end
      3: if (h == 10 && v == 10) check("poschg old pos", sif.rom_addr16, 100);
      4: begin
        if (h == 30 && v == 5)  check("newpos first", sif.rom_addr16, 0);
        if (h == 49 && v == 14) check("newpos last",  sif.rom_addr16, 199);
      end
      6: if (h == 10 && v == 5) begin
        check("post-reset cnt",  sif.pix_cnt,    1);
        check("post-reset addr", sif.rom_addr16, 0);
      end
      7: begin
        if (h == 20 && v == 7 && fs) check("abort cnt", sif.pix_cnt, 0);
        if (h == 21 && v == 7) begin
          check("abort addr", sif.rom_addr16, 11);
          check("abort cnt1", sif.pix_cnt,    1);
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_frame(input int test, input bit do_fs);
    int ph, pv;
    bit pde, pfs;
    ph = 0; pv = 0; pde = 0; pfs = 0;
    done_pulses = 0;
    tick();
    sif.frame_start = do_fs;
    sif.line_start  = 1'b0;
    sif.de          = 1'b0;
    for (int v = 0; v < SCR_H + V_BL; v++) begin
      for (int h = 0; h < SCR_W + H_BL; h++) begin
        tick();
        probe(test, ph, pv, pde, pfs);
        sif.frame_start = 1'b0;
        sif.line_start  = (h == SCR_W + 1);
        sif.de          = (h < SCR_W) && (v < SCR_H);
        sif.h_cnt       = 11'(h);
        sif.v_cnt       = 11'(v);
        if (test == 3 && v == 10 && h == 0) sif.pos_x = 11'd30;
        if (test == 7 && v == 7 && h == 20) sif.frame_start = 1'b1;
        if (test == 5 && v == 15 && h == 40) begin
          rst_n = 1'b0;
          #1;
          check_zero("reset mid-frame");
        end
        if (test == 5 && v == 15 && h == 50) rst_n = 1'b1;
        ph = h; pv = v; pde = sif.de; pfs = sif.frame_start;
      end
    end
    tick();
    probe(test, ph, pv, pde, pfs);
    sif.de         = 1'b0;
    sif.line_start = 1'b0;
  endtask

  task automatic set_pos(input int x, input int y);
    sif.pos_x = 11'(x);
    sif.pos_y = 11'(y);
  endtask

  initial begin
    sif.frame_start = 1'b0;
    sif.line_start  = 1'b0;
    sif.de          = 1'b0;
    sif.h_cnt       = '0;
    sif.v_cnt       = '0;
    set_pos(10, 5);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // No frame_start yet: nothing may be counted.
    run_frame(0, 1'b0);
    check("idle pix_cnt", sif.pix_cnt, 0);

    // Single isolated pixel latency.
    tick(); sif.frame_start = 1'b1;
    tick(); sif.frame_start = 1'b0;
    sif.de = 1'b1; sif.h_cnt = 11'd12; sif.v_cnt = 11'd6;
    tick();
    check("lat addr n+1", sif.rom_addr16, 2);
    check("lat vld n+1",  sif.pix_vld,    0);
    check("lat cnt n+1",  sif.pix_cnt,    1);
    sif.de = 1'b0;
    tick();
    check("lat vld n+2",  sif.pix_vld,    1);
    tick();
    check("lat vld n+3",  sif.pix_vld,    0);

    set_pos(10, 5);
    run_frame(1, 1'b1);
    check("basic pix_cnt", sif.pix_cnt, 200);
    check("basic done pulses", done_pulses, 1);

    set_pos(54, 0);
    run_frame(2, 1'b1);
    check("clip pix_cnt", sif.pix_cnt, 100);
    check("clip done pulses", done_pulses, 0);

    set_pos(10, 5);
    run_frame(3, 1'b1);
    check("poschg pix_cnt", sif.pix_cnt, 200);
    run_frame(4, 1'b1);
    check("newpos pix_cnt", sif.pix_cnt, 200);
    check("newpos done pulses", done_pulses, 1);

    set_pos(10, 5);
    run_frame(5, 1'b1);
    check("reset frame pix_cnt", sif.pix_cnt, 0);
    run_frame(6, 1'b1);
    check("after reset pix_cnt", sif.pix_cnt, 200);

    run_frame(7, 1'b1);
    check("abort pix_cnt", sif.pix_cnt, 149);
    check("abort done pulses", done_pulses, 1);

    set_pos(10, 28);
    run_frame(8, 1'b1);
    check("bottom clip pix_cnt", sif.pix_cnt, 80);
    check("bottom clip done pulses", done_pulses, 0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sprite_addr_gen.md
# sprite_addr_gen

- Generates the sprite-ROM read address and the running box-pixel count for a BOX_W×BOX_H sprite square placed at a programmable screen position.
- Sits between the VGA timing generator and the ROM address selector.
- Its rom_addr16 output feeds the selector's sprite address input, and its pix_cnt output feeds the selector's progress flag input.
- Also provides a pixel-valid strobe aligned with synchronous ROM read data.

## Interface
- BOX_W, 200, sprite width in pixels.
- BOX_H, 200, sprite height in pixels; BOX_W*BOX_H must be ≤ 65536.
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse on the first cycle of each frame, before any active pixel.
- line_start  in  1  one-cycle pulse at the start of each line, inside blanking.
- de  in  1  active-video enable.
- h_cnt  in  11  current active column.
- v_cnt  in  11  current active row.
- pos_x  in  11  box left edge (screen x).
- pos_y  in  11  box top edge (screen y).
- rom_addr16  out  16  sprite ROM address, registered.
- pix_cnt  out  16  box pixels emitted this frame, saturating at 16'hFFFF.
- pix_vld  out  1  high when ROM read data for a box pixel is present (1 cycle after rom_addr16).
- frame_done  out  1  one-cycle pulse when the last box pixel of the frame has been addressed.

## Operation
- **Reset values:** rom_addr16=0, pix_cnt=0, pix_vld=0, frame_done=0; internal px/py latches=0, row_base=0, state=IDLE.
- **frame_start:**
  - latches px←pos_x, py←pos_y; position changes take effect only at the next frame.
  - clears row_base and pix_cnt to 0.
  - state→ACTIVE from any state, including mid-frame.
- **in_box (combinational):** de & (h_cnt − px) < BOX_W & (v_cnt − py) < BOX_H.
  - Both differences are unsigned 11-bit subtractions, so columns/rows left of or above the box wrap large and are excluded.
- **On an in_box cycle in ACTIVE:**
  - rom_addr16 ← row_base + (h_cnt − px), zero-extended to 16 bits.
  - pix_cnt ← pix_cnt + 1, saturating.
  - Off-box cycles hold rom_addr16.
- **row_base:**
  - Per-line flag row_hit is set on any in_box cycle.
  - On line_start with row_hit=1: row_base += BOX_W, then row_hit clears.
  - Clipped rows (box partially off the right edge) still advance row_base, so rows stay aligned.
  - Rows fully off-screen vertically are never hit; they are not advanced and not counted.
- **States:**
  - IDLE: after reset until the first frame_start; no counting.
  - ACTIVE: counting.
  - DONE: entered when an in_box cycle has (h_cnt−px)=BOX_W−1 and (v_cnt−py)=BOX_H−1; frame_done pulses that cycle; further in_box cycles are ignored until the next frame_start.
- **Clipping at the right or bottom edge:** DONE is never reached, frame_done never pulses, and pix_cnt reflects only visible pixels.
- **frame_start coincident with an in_box cycle:** frame_start wins; the pixel is not counted.

## Timing
- in_box at cycle n → rom_addr16 and pix_cnt updated at edge n+1.
- pix_vld=1 during cycle n+2, aligned with ROM dout for a 1-cycle synchronous ROM.
- frame_done is a registered pulse, visible in cycle n+1 for last-pixel cycle n.
- line_start and in_box in the same cycle cannot occur (line_start is in blanking); if it occurs, row_base updates first and that pixel uses the new base.
- Reset asserted mid-frame clears all state immediately (asynchronously); counting resumes only after the next frame_start.

## Test plan
- **Basic frame:** reset; frame_start; pos=(100,50); full 640×480 raster → first in_box at (100,50) gives rom_addr16=0; (299,50) gives 199; (100,51) gives 200; final pixel gives 39999 with frame_done; pix_cnt=40000.
- **Latency:** single in_box pixel at cycle n → rom_addr16 changes at n+1; pix_vld=1 only during n+2.
- **Right clip:** pos=(540,0) → addresses per row 0..99, then 200..299, etc.; pix_cnt=100×200=20000; frame_done never pulses.
- **Mid-frame position change:** pos_x changed halfway through the frame → addresses unchanged until the next frame_start, then follow the new position.
- **Reset mid-frame:** rst_n low at pixel 1000 → all outputs 0 in the same cycle; after release and a new frame_start, pix_cnt restarts at 1.
- **Abort:** frame_start asserted mid-box → pix_cnt=0 and row_base=0; the next in_box pixel yields rom_addr16=(h_cnt−px).
